song_sequencer: RTL and testbench

- Autoplay controller for the piano.
- Steps through a song ROM one note word at a time and holds each note for a programmed number of beats.
- Beats come from the slow beat-tick counter (one-cycle pulse per beat).
- Drives the note code and gate into the tone generator, with start/pause/stop control from the key/button front end.

---
 rtl/piano_pkg.sv | 23 ++
 rtl/beat_down_counter.sv | 39 +++
 rtl/song_sequencer.sv | 162 ++++++++++++++++
 tb/tb_song_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared types and constants for the piano autoplay logic
// Contents: sequencer state enum, rest/end-of-song codes, default field widths
//           of the song ROM word {dur, note}.
package piano_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      PLAY,
      PAUSED
   } seq_state_t;

   // Default widths of the song ROM address and of the two word fields.
   localparam int DEF_ADDR_W = 6;
   localparam int DEF_NOTE_W = 5;
   localparam int DEF_DUR_W  = 4;

   // Note code 0 is silence; duration 0 marks the end of the song.
   localparam int NOTE_REST = 0;
   localparam int DUR_END   = 0;

endpackage

// File: rtl/beat_down_counter.sv
// rtl/beat_down_counter.sv - loadable beat down-counter holding a note's remaining beats
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       load i_load_val (wins over counting)
//   i_load_val   value to load
//   i_tick_en    decrement request (one beat elapsed)
//   i_hold       suppresses the decrement this cycle
//   o_is_zero    count == 0
//   o_is_one     count == 1
module beat_down_counter #(
   parameter int DUR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [DUR_W-1:0] i_load_val,
   input  logic             i_tick_en,
   input  logic             i_hold,
   output logic             o_is_zero,
   output logic             o_is_one
);

   logic [DUR_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_tick_en && !i_hold && (r_count != '0)) begin
         // Saturates at zero so a stray tick can never wrap the count.
         r_count <= r_count - 1'b1;
      end
   end

   assign o_is_zero = (r_count == '0);
   assign o_is_one  = (r_count == DUR_W'(1));

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - piano autoplay controller stepping through a song ROM
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   beat_tick    one-cycle pulse per beat
//   start        start from IDLE / resume from PAUSED
//   pause        pause request (honoured in PLAY only)
//   stop         abort to IDLE (highest priority)
//   loop_en      restart at address 0 at end of song
//   rom_addr     song ROM address (synchronous ROM, data one cycle later)
//   rom_data     ROM word {dur, note}
//   note, gate   note code and sound enable to the tone generator
//   busy         high in every state except IDLE
//   done         one-cycle pulse when the song ends without looping
module song_sequencer
   import piano_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NOTE_W = DEF_NOTE_W,
   parameter int DUR_W  = DEF_DUR_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    beat_tick,
   input  logic                    start,
   input  logic                    pause,
   input  logic                    stop,
   input  logic                    loop_en,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DUR_W+NOTE_W-1:0] rom_data,
   output logic [NOTE_W-1:0]       note,
   output logic                    gate,
   output logic                    busy,
   output logic                    done
);

   seq_state_t         r_state;
   logic [ADDR_W-1:0]  r_rom_addr;
   logic [NOTE_W-1:0]  r_note;
   logic               r_gate;
   logic               r_busy;
   logic               r_done;

   logic [DUR_W-1:0]   w_dur;
   logic [NOTE_W-1:0]  w_note;
   logic               w_stop;
   logic               w_dur_end;
   logic               w_last_addr;
   logic               w_rem_one;
   logic               w_rem_zero;
   logic               w_note_over;
   logic               w_song_end;
   logic               w_cnt_load;
   logic [DUR_W-1:0]   w_cnt_val;

   assign w_dur  = rom_data[NOTE_W +: DUR_W];
   assign w_note = rom_data[NOTE_W-1:0];

   assign w_stop      = stop && (r_state != IDLE);
   assign w_dur_end   = (r_state == LOAD) && (w_dur == DUR_W'(DUR_END));
   assign w_last_addr = &r_rom_addr;

   // A note is over on the tick that consumes its last beat; a pause in the
   // same cycle swallows the tick. The zero case only guards against a
   // counter that somehow holds 0 in PLAY, which would otherwise hang.
   assign w_note_over = (r_state == PLAY) && !pause && beat_tick
                        && (w_rem_one || w_rem_zero);

   // Running off the top of the ROM is an end of song, never a wrap.
   assign w_song_end = w_dur_end || (w_note_over && w_last_addr);

   // Stop clears the beat count; LOAD of a real note arms it.
   assign w_cnt_load = w_stop || ((r_state == LOAD) && !w_dur_end);
   assign w_cnt_val  = w_stop ? '0 : w_dur;

   beat_down_counter #(
      .DUR_W(DUR_W)
   ) u_beat_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_tick_en  ((r_state == PLAY) && beat_tick),
      .i_hold     (pause),
      .o_is_zero  (w_rem_zero),
      .o_is_one   (w_rem_one)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rom_addr <= '0;
         r_note     <= '0;
         r_gate     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_stop) begin
            r_state    <= IDLE;
            r_rom_addr <= '0;
            r_note     <= '0;
            r_gate     <= 1'b0;
            r_busy     <= 1'b0;
         end else if (w_song_end) begin
            r_gate     <= 1'b0;
            r_rom_addr <= '0;
            if (loop_en) begin
               r_state <= FETCH;
            end else begin
               r_state <= IDLE;
               r_note  <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     r_state    <= FETCH;
                     r_rom_addr <= '0;
                     r_busy     <= 1'b1;
                  end
               end
               FETCH: begin
                  r_state <= LOAD;
               end
               LOAD: begin
                  r_note  <= w_note;
                  r_gate  <= (w_note != NOTE_W'(NOTE_REST));
                  r_state <= PLAY;
               end
               PLAY: begin
                  if (pause) begin
                     r_state <= PAUSED;
                     r_gate  <= 1'b0;
                  end else if (w_note_over) begin
                     r_gate     <= 1'b0;
                     r_rom_addr <= r_rom_addr + 1'b1;
                     r_state    <= FETCH;
                  end
               end
               PAUSED: begin
                  if (start) begin
                     r_state <= PLAY;
                     r_gate  <= (r_note != NOTE_W'(NOTE_REST));
                  end
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign rom_addr = r_rom_addr;
   assign note     = r_note;
   assign gate     = r_gate;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - self-checking bench for song_sequencer
module tb_song_sequencer;

   localparam int ADDR_W = 3;
   localparam int NOTE_W = 5;
   localparam int DUR_W  = 4;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    beat_tick = 1'b0;
   logic                    start = 1'b0;
   logic                    pause = 1'b0;
   logic                    stop = 1'b0;
   logic                    loop_en = 1'b0;
   logic [ADDR_W-1:0]       rom_addr;
   logic [DUR_W+NOTE_W-1:0] rom_data;
   logic [NOTE_W-1:0]       note;
   logic                    gate;
   logic                    busy;
   logic                    done;

   logic [DUR_W+NOTE_W-1:0] rom_mem [8];

   typedef struct {
      bit         st;
      bit         pa;
      bit         sp;
      bit         tk;
      int         pre;
      int         settle;
      logic [4:0] note;
      bit         gate;
      bit         busy;
      bit         done;
      logic [2:0] addr;
   } vec_t;

   typedef struct packed {
      logic [4:0] note;
      logic       gate;
      logic       busy;
      logic       done;
      logic [2:0] addr;
   } exp_t;

   vec_t  vecs[$];
   exp_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    done_cnt = 0;
   int    done_base = 0;
   int    vidx = 0;
   string sect = "reset";

   song_sequencer #(
      .ADDR_W(ADDR_W),
      .NOTE_W(NOTE_W),
      .DUR_W (DUR_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .beat_tick(beat_tick),
      .start    (start),
      .pause    (pause),
      .stop     (stop),
      .loop_en  (loop_en),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .note     (note),
      .gate     (gate),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Synchronous song ROM: word appears one cycle after the address.
   always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   function automatic void add(bit st, bit pa, bit sp, bit tk, int pre, int settle,
                               logic [4:0] n, bit g, bit b, bit d, logic [2:0] a);
      vecs.push_back('{st, pa, sp, tk, pre, settle, n, g, b, d, a});
   endfunction

   function automatic void rom_fill(logic [8:0] w);
      for (int i = 0; i < 8; i++) rom_mem[i] = w;
   endfunction

   task automatic check_out();
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s[%0d]: scoreboard empty", sect, vidx);
         return;
      end
      e = exp_q.pop_front();
      if (note !== e.note || gate !== e.gate || busy !== e.busy ||
          done !== e.done || rom_addr !== e.addr) begin
         errors++;
         $display("FAIL %s[%0d]: got note=%0d gate=%b busy=%b done=%b addr=%0d, expected note=%0d gate=%b busy=%b done=%b addr=%0d",
                  sect, vidx, note, gate, busy, done, rom_addr,
                  e.note, e.gate, e.busy, e.done, e.addr);
      end
   endtask

   // Called at a negedge; drives one cycle of inputs, then samples
   // 'settle' edges after the sampling edge.
   task automatic apply(input vec_t v);
      repeat (v.pre) @(negedge clk);
      start     = v.st;
      pause     = v.pa;
      stop      = v.sp;
      beat_tick = v.tk;
      exp_q.push_back('{v.note, v.gate, v.busy, v.done, v.addr});
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      pause     = 1'b0;
      stop      = 1'b0;
      beat_tick = 1'b0;
      repeat (v.settle) @(negedge clk);
      check_out();
   endtask

   task automatic run_vecs();
      for (int i = 0; i < vecs.size(); i++) begin
         vidx = i;
         apply(vecs[i]);
      end
      vecs.delete();
   endtask

   task automatic check_done(input int want);
      checks++;
      if (done_cnt - done_base != want) begin
         errors++;
         $display("FAIL %s done_pulses: got %0d, expected %0d", sect, done_cnt - done_base, want);
      end
      done_base = done_cnt;
   endtask

   initial begin
      rom_fill(9'd0);
      repeat (3) @(negedge clk);
      vidx = 0;
      exp_q.push_back('{5'd0, 1'b0, 1'b0, 1'b0, 3'd0});
      check_out();
      rst_n = 1'b1;
      @(negedge clk);

      // Basic playback, ticks 20 cycles apart
      sect = "basic";
      rom_fill(9'd0);
      rom_mem[0] = {4'd2, 5'd5};
      rom_mem[1] = {4'd1, 5'd0};
      rom_mem[2] = {4'd0, 5'd0};
      loop_en = 1'b0;
      add(1,0,0,0,  0,1, 5'd0,0,1,0,3'd0);
      add(0,0,0,0,  0,0, 5'd5,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd5,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd5,0,1,0,3'd1);
      add(0,0,0,0,  0,1, 5'd0,0,1,0,3'd1);
      add(0,0,0,1, 19,0, 5'd0,0,1,0,3'd2);
      add(0,0,0,0,  0,1, 5'd0,0,0,1,3'd0);
      add(0,0,0,0,  0,0, 5'd0,0,0,0,3'd0);
      run_vecs();
      check_done(1);

      // Looping replays from address 0, then stop
      sect = "loop";
      loop_en = 1'b1;
      add(1,0,0,0,  0,2, 5'd5,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd5,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd5,0,1,0,3'd1);
      add(0,0,0,0,  0,1, 5'd0,0,1,0,3'd1);
      add(0,0,0,1, 19,0, 5'd0,0,1,0,3'd2);
      add(0,0,0,0,  0,1, 5'd0,0,1,0,3'd0);
      add(0,0,0,0,  0,1, 5'd5,1,1,0,3'd0);
      add(0,0,1,0,  5,0, 5'd0,0,0,0,3'd0);
      add(0,0,0,0,  0,0, 5'd0,0,0,0,3'd0);
      run_vecs();
      loop_en = 1'b0;
      check_done(0);

      // Pause / resume
      sect = "pause";
      rom_fill(9'd0);
      rom_mem[0] = {4'd4, 5'd9};
      add(1,0,0,0,  0,2, 5'd9,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd9,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd9,1,1,0,3'd0);
      add(0,1,0,0,  5,0, 5'd9,0,1,0,3'd0);
      for (int i = 0; i < 5; i++) add(0,0,0,1, 19,0, 5'd9,0,1,0,3'd0);
      add(1,0,0,0,  5,0, 5'd9,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd9,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd9,0,1,0,3'd1);
      add(0,0,0,0,  0,1, 5'd0,0,0,1,3'd0);
      add(0,0,0,0,  0,0, 5'd0,0,0,0,3'd0);
      run_vecs();
      check_done(1);

      // Simultaneous controls
      sect = "simul";
      add(1,0,0,0,  0,2, 5'd9,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd9,1,1,0,3'd0);
      add(0,1,0,1, 19,0, 5'd9,0,1,0,3'd0);
      add(1,0,0,0,  5,0, 5'd9,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd9,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd9,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd9,0,1,0,3'd1);
      add(0,0,0,0,  0,1, 5'd0,0,0,1,3'd0);
      add(1,0,0,0,  5,2, 5'd9,1,1,0,3'd0);
      add(1,0,0,0,  5,0, 5'd9,1,1,0,3'd0);
      add(1,1,1,0,  5,0, 5'd0,0,0,0,3'd0);
      add(0,0,0,0,  0,3, 5'd0,0,0,0,3'd0);
      add(0,1,0,0,  2,1, 5'd0,0,0,0,3'd0);
      run_vecs();
      check_done(1);

      // Address boundary: no end marker, must end after address 7
      sect = "boundary";
      for (int i = 0; i < 8; i++) rom_mem[i] = {4'd1, 5'(i + 1)};
      add(1,0,0,0,  0,2, 5'd1,1,1,0,3'd0);
      for (int i = 0; i < 7; i++) begin
         add(0,0,0,1, 19,0, 5'(i + 1),0,1,0,3'(i + 1));
         add(0,0,0,0,  0,1, 5'(i + 2),1,1,0,3'(i + 1));
      end
      add(0,0,0,1, 19,0, 5'd0,0,0,1,3'd0);
      add(0,0,0,0,  0,3, 5'd0,0,0,0,3'd0);
      run_vecs();
      check_done(1);

      // Asynchronous reset during PLAY
      sect = "async_reset";
      add(1,0,0,0,  0,2, 5'd1,1,1,0,3'd0);
      add(0,0,0,1, 19,0, 5'd1,0,1,0,3'd1);
      add(0,0,0,0,  0,1, 5'd2,1,1,0,3'd1);
      run_vecs();
      #2 rst_n = 1'b0;
      #1;
      vidx = 100;
      exp_q.push_back('{5'd0, 1'b0, 1'b0, 1'b0, 3'd0});
      check_out();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      add(0,0,0,0,  4,0, 5'd0,0,0,0,3'd0);
      add(1,0,0,0,  0,2, 5'd1,1,1,0,3'd0);
      add(0,0,1,0,  0,0, 5'd0,0,0,0,3'd0);
      run_vecs();
      check_done(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
